psum_accumulator: RTL and testbench
===================================

# psum_accumulator

Output-side accumulation buffer sitting directly downstream of a PE column. It captures the 32-bit `outPartialSum` stream produced by the last PE of the column over several passes. Each pass (e.g. one filter-channel group) adds element-wise into a local register buffer, and the finished sums drain to the output interface under a valid/ready handshake.

## Interface
Parameters:
- `accumulationPar`, 32: psum width, two's complement; matches PE output width.
- `DEPTH`, 16: psums per pass (buffer entries); power of two, ≥2.
- `PASSES`, 4: passes accumulated before drain; ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous abort; returns to FILL, counters 0, `sat_flag` 0; buffer contents don't-care.
- `in_valid`  in  1  `in_psum` valid.
- `in_psum`  in  accumulationPar  psum from PE column.
- `in_ready`  out  1  accept; 1 in FILL/ACCUM, 0 in DRAIN.
- `out_valid`  out  1  `out_psum` valid; 1 only in DRAIN.
- `out_psum`  out  accumulationPar  accumulated result `buf[rd_idx]`.
- `out_ready`  in  1  consumer accept.
- `out_last`  out  1  high with the final (index DEPTH-1) output.
- `sat_flag`  out  1  sticky saturation indicator; constant 0 unless `PSUM_SATURATE_EN`.

## Operation
- States: FILL (pass 0), ACCUM (passes 1..PASSES-1), DRAIN.
- Input beat = `in_valid & in_ready` at a rising edge. Beats arrive in index order 0..DEPTH-1 per pass; `wr_idx` counts beats, `pass_cnt` counts passes.
- FILL: beat writes `buf[wr_idx] <= in_psum` (overwrite, no add). At `wr_idx==DEPTH-1`: go to ACCUM with `pass_cnt=1`, or to DRAIN if PASSES==1.
- ACCUM: beat writes `buf[wr_idx] <= buf[wr_idx] + in_psum`, full-width signed add, wrapping. At `wr_idx==DEPTH-1`: if `pass_cnt==PASSES-1`, go to DRAIN; otherwise increment `pass_cnt`.
- `wr_idx` wraps DEPTH-1→0 on every pass boundary.
- DRAIN: `out_valid=1`, `out_psum=buf[rd_idx]`. An output beat (`out_valid & out_ready`) increments `rd_idx`. The beat at `rd_idx==DEPTH-1` (`out_last=1`) returns to FILL with all counters 0.
- `out_psum`/`out_last` hold stable while `out_valid & ~out_ready`.
- `in_valid` during DRAIN is ignored (not accepted, no state change).
- `clear` has priority over any beat in the same cycle; the beat is dropped.
- `sat_flag` is cleared on entry to FILL from DRAIN and by `clear`/`rst`.

## Timing
- Reset (async assert): state FILL, counters 0, `in_ready=1`, `out_valid=0`, `out_psum=0` (buffer reset to 0), `out_last=0`, `sat_flag=0`.
- Input-to-buffer latency: 1 cycle. A beat at edge N is visible in `buf` after edge N.
- Last input beat at edge N → `out_valid=1` from edge N onward (first output cycle N+1 window). No bubble.
- Throughput: 1 input beat/cycle in FILL/ACCUM; 1 output beat/cycle with `out_ready` held high.
- After final output beat at edge M, `in_ready=1` in the cycle following edge M.
- Full frame latency = DEPTH·PASSES input beats + DEPTH output beats; no overlap between drain and next fill.

## Configuration
- `PSUM_SATURATE_EN` defined: ACCUM add saturates on signed overflow to 0x7FFF_FFFF (pos) or 0x8000_0000 (neg) for the 32-bit default, and sets `sat_flag` (sticky).
- Not defined: add wraps modulo 2^accumulationPar and `sat_flag` is tied 0.

## Structure
- Package `psum_pkg`: state enum `psum_state_t {FILL, ACCUM, DRAIN}`; width helper constants for `wr_idx`/`rd_idx` (`$clog2(DEPTH)`) and `pass_cnt` (`$clog2(PASSES)`, min 1).
- Sub-module `psum_sat_adder`: signed add with optional saturation (macro-controlled), output overflow bit. Buffer, counters and FSM stay in the top.

## Test plan
- Reset mid-ACCUM (pass 2, idx 5) → all outputs at reset values immediately; next frame's first pass overwrites.
- DEPTH=16, PASSES=4, `in_psum=idx+1` every pass, `out_ready=1` → outputs 4,8,…,64, `out_last` on 64, then `in_ready=1`.
- Same frame with `out_ready` toggling 1010… → identical output sequence, values stable during stalls, 16 beats total.
- `in_valid` held high through DRAIN with value 99 → ignored; next frame output unaffected.
- `clear` asserted at pass 1 idx 7 with `in_valid=1` → beat dropped, state FILL, `wr_idx=0`; fresh frame results correct.
- With `PSUM_SATURATE_EN`: pass 0 writes 0x7FFF_FFF0 and pass 1 adds 0x20 → output 0x7FFF_FFFF, `sat_flag=1`. Without the macro: output 0x8000_0010, `sat_flag=0`.

Source files
------------

// File: rtl/psum_pkg.sv
// Shared types and width helpers for the partial-sum accumulation buffer.
package psum_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } psum_state_t;

  function automatic int idxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // A single-pass build still needs a 1-bit pass counter.
  function automatic int passWidth(input int passes);
    return (passes > 1) ? $clog2(passes) : 1;
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Stream-in / stream-out bundle of the psum accumulator.
// Handshake: a beat occurs on a rising edge where valid & ready are both high;
// the producer holds data stable while valid & ~ready, and ready never depends on valid.
interface psum_accumulator_if #(
  parameter int accumulationPar = 32
);
  logic                       clear;
  logic                       in_valid;
  logic [accumulationPar-1:0] in_psum;
  logic                       in_ready;
  logic                       out_valid;
  logic [accumulationPar-1:0] out_psum;
  logic                       out_ready;
  logic                       out_last;
  logic                       sat_flag;

  modport master (
    output clear, in_valid, in_psum, out_ready,
    input  in_ready, out_valid, out_psum, out_last, sat_flag
  );

  modport slave (
    input  clear, in_valid, in_psum, out_ready,
    output in_ready, out_valid, out_psum, out_last, sat_flag
  );
endinterface

// File: rtl/psum_sat_adder.sv
// Signed adder with an overflow flag; clamps to the signed limits when PSUM_SATURATE_EN is defined.
module psum_sat_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);
  logic [W-1:0] raw;

  assign raw = a + b;
  // Overflow only when both operands share a sign that the result lost.
  assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef PSUM_SATURATE_EN
  assign sum = ovf ? (a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : raw;
`else
  assign sum = raw;
`endif
endmodule

// File: rtl/psum_accumulator.sv
// Multi-pass element-wise accumulation buffer behind a PE column, drained over valid/ready.
// Optional feature: PSUM_SATURATE_EN makes the accumulate add saturate and drives sat_flag.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int accumulationPar = 32,
  parameter int DEPTH           = 16,
  parameter int PASSES          = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  psum_accumulator_if.slave             bus,
  output logic [1:0]                    dbgState,
  output logic [idxWidth(DEPTH)-1:0]    dbgWrIdx
);
  localparam int IW = idxWidth(DEPTH);
  localparam int PW = passWidth(PASSES);

  localparam logic [1:0]    stFill   = FILL;
  localparam logic [1:0]    stAccum  = ACCUM;
  localparam logic [1:0]    stDrain  = DRAIN;
  localparam logic [IW-1:0] lastIdx  = IW'(DEPTH - 1);
  localparam logic [PW-1:0] lastPass = PW'(PASSES - 1);

`ifdef PSUM_SATURATE_EN
  localparam bit satEn = 1'b1;
`else
  localparam bit satEn = 1'b0;
`endif

  logic [1:0]                 state;
  logic [IW-1:0]              wrIdx;
  logic [IW-1:0]              rdIdx;
  logic [PW-1:0]              passCnt;
  logic                       satFlag;
  logic [accumulationPar-1:0] buffer [DEPTH];
  logic [accumulationPar-1:0] addSum;
  logic                       addOvf;
  logic                       inBeat;
  logic                       outBeat;

  assign bus.in_ready  = (state != stDrain);
  assign bus.out_valid = (state == stDrain);
  assign bus.out_psum  = buffer[rdIdx];
  assign bus.out_last  = (state == stDrain) && (rdIdx == lastIdx);
  assign bus.sat_flag  = satFlag;

  assign inBeat  = bus.in_valid & bus.in_ready;
  assign outBeat = bus.out_valid & bus.out_ready;

  assign dbgState = state;
  assign dbgWrIdx = wrIdx;

  psum_sat_adder #(.W(accumulationPar)) u_adder (
    .a   (buffer[wrIdx]),
    .b   (bus.in_psum),
    .sum (addSum),
    .ovf (addOvf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= stFill;
      wrIdx   <= '0;
      rdIdx   <= '0;
      passCnt <= '0;
      satFlag <= 1'b0;
      for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
    end else if (bus.clear) begin
      // Abort drops any same-cycle beat; buffer contents are left as-is.
      state   <= stFill;
      wrIdx   <= '0;
      rdIdx   <= '0;
      passCnt <= '0;
      satFlag <= 1'b0;
    end else begin
      case (state)
        stFill: begin
          if (inBeat) begin
            buffer[wrIdx] <= bus.in_psum;
            wrIdx         <= wrIdx + IW'(1);
            if (wrIdx == lastIdx) begin
              if (PASSES == 1) begin
                state <= stDrain;
              end else begin
                state   <= stAccum;
                passCnt <= PW'(1);
              end
            end
          end
        end
        stAccum: begin
          if (inBeat) begin
            buffer[wrIdx] <= addSum;
            wrIdx         <= wrIdx + IW'(1);
            satFlag       <= satFlag | (satEn & addOvf);
            if (wrIdx == lastIdx) begin
              if (passCnt == lastPass) state <= stDrain;
              else                     passCnt <= passCnt + PW'(1);
            end
          end
        end
        stDrain: begin
          if (outBeat) begin
            rdIdx <= rdIdx + IW'(1);
            if (rdIdx == lastIdx) begin
              state   <= stFill;
              rdIdx   <= '0;
              wrIdx   <= '0;
              passCnt <= '0;
              satFlag <= 1'b0;
            end
          end
        end
        default: begin
          state <= stFill;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized bench for psum_accumulator against a per-element arithmetic reference model.
module tb_psum_accumulator;
  import psum_pkg::*;

  localparam int W      = 32;
  localparam int DEPTH  = 16;
  localparam int PASSES = 4;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic [3:0] dbg_wr_idx;

  psum_accumulator_if #(.accumulationPar(W)) bus ();

  psum_accumulator #(
    .accumulationPar (W),
    .DEPTH           (DEPTH),
    .PASSES          (PASSES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbg_state),
    .dbgWrIdx (dbg_wr_idx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] stim [PASSES][DEPTH];
  logic [W-1:0] exp_q[$];
  logic         exp_sat;

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // reference model: each element is the signed sum of its column across passes
  task automatic build_expected();
    longint acc;
    logic [63:0] acc_bits;
    exp_q.delete();
    exp_sat = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      acc = longint'($signed(stim[0][i]));
      for (int p = 1; p < PASSES; p++) begin
        acc = acc + longint'($signed(stim[p][i]));
`ifdef PSUM_SATURATE_EN
        if (acc > 64'sd2147483647) begin
          acc = 64'sd2147483647;
          exp_sat = 1'b1;
        end else if (acc < -64'sd2147483648) begin
          acc = -64'sd2147483648;
          exp_sat = 1'b1;
        end
`endif
        acc_bits = acc;
        acc = longint'($signed(acc_bits[31:0]));
      end
      acc_bits = acc;
      exp_q.push_back(acc_bits[31:0]);
    end
  endtask

  task automatic stim_random();
    for (int p = 0; p < PASSES; p++)
      for (int i = 0; i < DEPTH; i++)
        stim[p][i] = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 1000));
  endtask

  task automatic stim_ramp();
    for (int p = 0; p < PASSES; p++)
      for (int i = 0; i < DEPTH; i++)
        stim[p][i] = W'(i + 1);
  endtask

  // driver: feeds the first 'count' beats of stim in index/pass order with random bubbles
  task automatic feed_beats(input int count);
    int k = 0;
    int guard = 0;
    while (k < count) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_psum  = stim[k / DEPTH][k % DEPTH];
        if (bus.in_ready) k++;
      end
      @(negedge clk);
      guard++;
      if (guard > 4 * count + 100) begin
        check_eq("feed_timeout", W'(k), W'(count));
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic feed_frame();
    build_expected();
    feed_beats(DEPTH * PASSES);
    check_eq("drain_entry_out_valid", W'(bus.out_valid), W'(1));
    check_eq("drain_entry_in_ready", W'(bus.in_ready), W'(0));
    check_eq("drain_entry_sat_flag", W'(bus.sat_flag), W'(exp_sat));
  endtask

  // mode 0: ready held high, 1: ready toggles 1010..., 2: random ready
  task automatic drain_frame(input int mode, input bit spam);
    int got = 0;
    int cyc = 0;
    while (got < DEPTH && cyc < 1000) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 2 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (spam) begin
        bus.in_valid = 1'b1;
        bus.in_psum  = W'(99);
      end
      check_eq("out_valid", W'(bus.out_valid), W'(1));
      check_eq("out_psum", bus.out_psum, exp_q[0]);
      check_eq("out_last", W'(bus.out_last), W'(got == DEPTH - 1));
      if (bus.out_valid && bus.out_ready) begin
        void'(exp_q.pop_front());
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    if (got != DEPTH) check_eq("drain_timeout", W'(got), W'(DEPTH));
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_eq("post_drain_in_ready", W'(bus.in_ready), W'(1));
    check_eq("post_drain_out_valid", W'(bus.out_valid), W'(0));
    check_eq("post_drain_sat_flag", W'(bus.sat_flag), W'(0));
    check_eq("post_drain_state", W'(dbg_state), W'(FILL));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_in_ready"}, W'(bus.in_ready), W'(1));
    check_eq({tag, "_out_valid"}, W'(bus.out_valid), W'(0));
    check_eq({tag, "_out_psum"}, bus.out_psum, W'(0));
    check_eq({tag, "_out_last"}, W'(bus.out_last), W'(0));
    check_eq({tag, "_sat_flag"}, W'(bus.sat_flag), W'(0));
    check_eq({tag, "_state"}, W'(dbg_state), W'(FILL));
  endtask

  initial begin
    rst           = 1'b1;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_psum   = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);

    // ramp frame, ready held high: 4, 8, ..., 64
    stim_ramp();
    feed_frame();
    check_eq("ramp_first", bus.out_psum, W'(4));
    drain_frame(0, 1'b0);

    // same frame with ready toggling
    stim_ramp();
    feed_frame();
    drain_frame(1, 1'b0);

    // input spam during drain must be ignored
    stim_random();
    feed_frame();
    drain_frame(2, 1'b1);

    // random frames with random back-pressure
    for (int f = 0; f < 6; f++) begin
      stim_random();
      feed_frame();
      drain_frame(2, f[0]);
    end

    // clear at pass 1 idx 7 with a concurrent beat
    stim_random();
    feed_beats(DEPTH + 7);
    bus.in_valid = 1'b1;
    bus.in_psum  = stim[1][7];
    bus.clear    = 1'b1;
    @(negedge clk);
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("clear_state", W'(dbg_state), W'(FILL));
    check_eq("clear_wr_idx", W'(dbg_wr_idx), W'(0));
    check_eq("clear_in_ready", W'(bus.in_ready), W'(1));
    check_eq("clear_out_valid", W'(bus.out_valid), W'(0));
    stim_random();
    feed_frame();
    drain_frame(2, 1'b0);

    // asynchronous reset mid-accumulation (pass 2, idx 5)
    stim_random();
    feed_beats(2 * DEPTH + 5);
    rst = 1'b1;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    stim_random();
    feed_frame();
    drain_frame(0, 1'b0);

    // overflow on element 0 between pass 0 and pass 1
    for (int p = 0; p < PASSES; p++)
      for (int i = 0; i < DEPTH; i++)
        stim[p][i] = W'($urandom_range(0, 50));
    stim[0][0] = 32'h7FFF_FFF0;
    stim[1][0] = 32'h0000_0020;
    stim[2][0] = 32'h0;
    stim[3][0] = 32'h0;
    feed_frame();
`ifdef PSUM_SATURATE_EN
    check_eq("ovf_value", bus.out_psum, 32'h7FFF_FFFF);
    check_eq("ovf_sat_flag", W'(bus.sat_flag), W'(1));
`else
    check_eq("ovf_value", bus.out_psum, 32'h8000_0010);
    check_eq("ovf_sat_flag", W'(bus.sat_flag), W'(0));
`endif
    drain_frame(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
